// File: rtl/shift_deser.sv
// -----------------------------------------------------------------------------
// shift_deser
//   Serial-to-parallel deserialiser. START opens a frame. Each SIN_VALID cycle
//   shifts one bit in, MSB first. After N accepted bits, the word is copied
//   to DATA. DATA_VALID then pulses for one cycle, and FULL is set until the
//   consumer acknowledges the word with RD. If a word completes while an
//   unacknowledged word is still held, and RD is not asserted in that cycle,
//   the sticky OVERRUN flag is set.
//
// Parameters
//   N           parallel word width (N >= 2)
//
// Ports
//   CLK         in   clock, rising edge
//   A_CLR_N     in   asynchronous active-low reset
//   START       in   frame-start / frame-restart strobe
//   SIN         in   serial data bit, MSB first
//   SIN_VALID   in   SIN carries a valid bit this cycle
//   RD          in   consumer acknowledge; clears FULL (and OVERRUN)
//   DATA        out  last completed word, held until the next completes
//   DATA_VALID  out  one-cycle pulse in the cycle after a word completes
//   FULL        out  DATA holds an unacknowledged word
//   BUSY        out  a frame is being shifted in
//   OVERRUN     out  sticky: a word overwrote an unacknowledged word
// -----------------------------------------------------------------------------
module shift_deser #(
  parameter int N = 16
) (
  input  logic         CLK,
  input  logic         A_CLR_N,
  input  logic         START,
  input  logic         SIN,
  input  logic         SIN_VALID,
  input  logic         RD,
  output logic [N-1:0] DATA,
  output logic         DATA_VALID,
  output logic         FULL,
  output logic         BUSY,
  output logic         OVERRUN
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   shreg_q;
  logic [N-1:0]   data_q;
  logic           data_valid_q;
  logic           full_q;
  logic           overrun_q;

  logic [N-1:0]   shreg_d;
  logic           accept;
  logic           complete;
  logic           overrun_evt;

  // START always wins over a simultaneous valid bit, including on the bit
  // that would otherwise complete the word.
  assign accept      = (state_q == SHIFT) && !START && SIN_VALID;
  assign complete    = accept && (cnt_q == CNT_LAST);
  assign overrun_evt = complete && full_q && !RD;
  assign shreg_d     = {shreg_q[N-2:0], SIN};

  // NOTE: state registers use non-blocking assignments so that every register
  // samples the pre-edge values of its neighbours, whatever the statement order.
  always_ff @(posedge CLK or negedge A_CLR_N) begin
    if (!A_CLR_N) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      full_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      data_valid_q <= complete;

      case (state_q)
        IDLE: begin
          // SIN_VALID is ignored here, including in the START cycle.
          if (START) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            shreg_q <= '0;
          end
        end
        SHIFT: begin
          if (START) begin
            // Restart: the partial word is dropped silently.
            cnt_q   <= '0;
            shreg_q <= '0;
          end else if (SIN_VALID) begin
            shreg_q <= shreg_d;
            if (cnt_q == CNT_LAST) begin
              data_q  <= shreg_d;
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // A completion in the same cycle as RD leaves FULL set, because the
      // acknowledge refers to the word that is being replaced.
      if (complete)  full_q <= 1'b1;
      else if (RD)   full_q <= 1'b0;

      // An overrun event takes priority over a clear by RD.
      if (overrun_evt) overrun_q <= 1'b1;
      else if (RD)     overrun_q <= 1'b0;
    end
  end

  assign DATA       = data_q;
  assign DATA_VALID = data_valid_q;
  assign FULL       = full_q;
  assign BUSY       = (state_q == SHIFT);
  assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_shift_deser.sv
// -----------------------------------------------------------------------------
// tb_shift_deser
//   Directed bench for shift_deser (N = 16). The inputs are driven 1 ns after
//   each rising edge, and the outputs are sampled at that same point. The
//   DATA_VALID pulses are counted on the falling edge.
// -----------------------------------------------------------------------------
module tb_shift_deser;

  localparam int N = 16;

  logic         CLK = 1'b0;
  logic         A_CLR_N;
  logic         START;
  logic         SIN;
  logic         SIN_VALID;
  logic         RD;
  logic [N-1:0] DATA;
  logic         DATA_VALID;
  logic         FULL;
  logic         BUSY;
  logic         OVERRUN;

  int checks   = 0;
  int errors   = 0;
  int dv_count = 0;
  int dv_base  = 0;

  always #5 CLK = ~CLK;

  shift_deser #(.N(N)) dut (
    .CLK        (CLK),
    .A_CLR_N    (A_CLR_N),
    .START      (START),
    .SIN        (SIN),
    .SIN_VALID  (SIN_VALID),
    .RD         (RD),
    .DATA       (DATA),
    .DATA_VALID (DATA_VALID),
    .FULL       (FULL),
    .BUSY       (BUSY),
    .OVERRUN    (OVERRUN)
  );

  always @(negedge CLK) if (DATA_VALID) dv_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    START     = 1'b0;
    SIN_VALID = 1'b0;
    RD        = 1'b0;
    repeat (n) tick();
  endtask

  task automatic start_frame(input logic sv);
    START     = 1'b1;
    SIN_VALID = sv;
    SIN       = 1'b1;
    RD        = 1'b0;
    tick();
    START     = 1'b0;
    SIN_VALID = 1'b0;
  endtask

  // Sends the top nbits of w, MSB first. With gaps set, 1..5 idle cycles
  // precede each bit. RD is raised with the last bit when rd_last is set.
  task automatic send_bits(input logic [N-1:0] w, input int nbits,
                           input bit gaps, input logic rd_last);
    for (int i = 0; i < nbits; i++) begin
      if (gaps) idle((i % 5) + 1);
      SIN       = w[N-1-i];
      SIN_VALID = 1'b1;
      RD        = (i == nbits - 1) ? rd_last : 1'b0;
      tick();
      SIN_VALID = 1'b0;
      RD        = 1'b0;
    end
  endtask

  task automatic ack();
    RD = 1'b1;
    tick();
    RD = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    A_CLR_N = 1'b0; START = 1'b0; SIN = 1'b0; SIN_VALID = 1'b0; RD = 1'b0;
    #2;
    check("rst_data", 32'(DATA), 32'h0);
    check("rst_dv",   32'(DATA_VALID), 32'h0);
    check("rst_full", 32'(FULL), 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_ovr",  32'(OVERRUN), 32'h0);
    tick(); tick();
    #2 A_CLR_N = 1'b1;
    tick();

    // Basic frame 0xA5C3, with the first START honoured straight after reset.
    dv_base = dv_count;
    start_frame(1'b0);
    check("basic_busy_start", 32'(BUSY), 32'h1);
    send_bits(16'hA5C3, N, 1'b0, 1'b0);
    check("basic_data", 32'(DATA), 32'hA5C3);
    check("basic_dv",   32'(DATA_VALID), 32'h1);
    check("basic_full", 32'(FULL), 32'h1);
    check("basic_busy", 32'(BUSY), 32'h0);
    check("basic_ovr",  32'(OVERRUN), 32'h0);
    idle(1);
    check("basic_dv_drop", 32'(DATA_VALID), 32'h0);
    check("basic_pulses", 32'(dv_count - dv_base), 32'h1);
    ack();
    check("basic_ack_full", 32'(FULL), 32'h0);

    // Gapped frame. SIN_VALID is asserted in IDLE and in the START cycle,
    // and both must be ignored.
    SIN = 1'b1; SIN_VALID = 1'b1;
    tick(); tick(); tick();
    check("idle_valid_busy", 32'(BUSY), 32'h0);
    dv_base = dv_count;
    start_frame(1'b1);
    send_bits(16'hA5C3, N, 1'b1, 1'b0);
    check("gap_data", 32'(DATA), 32'hA5C3);
    idle(2);
    check("gap_pulses", 32'(dv_count - dv_base), 32'h1);
    ack();

    // Restart mid-frame. The START that restarts the frame carries a valid
    // bit, which must be discarded.
    dv_base = dv_count;
    start_frame(1'b0);
    send_bits(16'hFE00, 7, 1'b0, 1'b0);
    start_frame(1'b1);
    check("restart_busy", 32'(BUSY), 32'h1);
    check("restart_data_held", 32'(DATA), 32'hA5C3);
    send_bits(16'h1234, N, 1'b0, 1'b0);
    check("restart_data", 32'(DATA), 32'h1234);
    idle(2);
    check("restart_pulses", 32'(dv_count - dv_base), 32'h1);
    ack();

    // START on the cycle that would complete the word. START wins.
    start_frame(1'b0);
    send_bits(16'hFFFF, N - 1, 1'b0, 1'b0);
    START = 1'b1; SIN_VALID = 1'b1; SIN = 1'b1;
    tick();
    START = 1'b0; SIN_VALID = 1'b0;
    check("startwin_dv",   32'(DATA_VALID), 32'h0);
    check("startwin_data", 32'(DATA), 32'h1234);
    check("startwin_busy", 32'(BUSY), 32'h1);
    send_bits(16'h5A5A, N, 1'b0, 1'b0);
    check("startwin_next", 32'(DATA), 32'h5A5A);
    ack();

    // Overrun, then an RD that clears both FULL and OVERRUN.
    start_frame(1'b0);
    send_bits(16'h00FF, N, 1'b0, 1'b0);
    check("ovr_first_ovr", 32'(OVERRUN), 32'h0);
    start_frame(1'b0);
    send_bits(16'hFF00, N, 1'b0, 1'b0);
    check("ovr_data", 32'(DATA), 32'hFF00);
    check("ovr_flag", 32'(OVERRUN), 32'h1);
    check("ovr_full", 32'(FULL), 32'h1);
    check("ovr_dv",   32'(DATA_VALID), 32'h1);
    ack();
    check("ovr_ack_full", 32'(FULL), 32'h0);
    check("ovr_ack_flag", 32'(OVERRUN), 32'h0);

    // RD asserted on the completion cycle.
    start_frame(1'b0);
    send_bits(16'h1111, N, 1'b0, 1'b0);
    start_frame(1'b0);
    send_bits(16'h2222, N, 1'b0, 1'b1);
    check("rdc_data", 32'(DATA), 32'h2222);
    check("rdc_full", 32'(FULL), 32'h1);
    check("rdc_ovr",  32'(OVERRUN), 32'h0);
    start_frame(1'b0);
    send_bits(16'h3333, N, 1'b0, 1'b0);
    check("rdc_ovr_set", 32'(OVERRUN), 32'h1);
    start_frame(1'b0);
    send_bits(16'h4444, N, 1'b0, 1'b1);
    check("rdc_ovr_clr",  32'(OVERRUN), 32'h0);
    check("rdc_full_kept", 32'(FULL), 32'h1);

    // Asynchronous reset between edges, 10 bits into a frame, with FULL set.
    start_frame(1'b0);
    send_bits(16'hBEEF, 10, 1'b0, 1'b0);
    check("arst_pre_busy", 32'(BUSY), 32'h1);
    #2 A_CLR_N = 1'b0;
    #1;
    check("arst_data", 32'(DATA), 32'h0);
    check("arst_full", 32'(FULL), 32'h0);
    check("arst_busy", 32'(BUSY), 32'h0);
    check("arst_dv",   32'(DATA_VALID), 32'h0);
    check("arst_ovr",  32'(OVERRUN), 32'h0);
    dv_base = dv_count;
    tick();
    #2 A_CLR_N = 1'b1;
    SIN = 1'b1; SIN_VALID = 1'b1;
    tick();
    SIN_VALID = 1'b0;
    tick();
    check("arst_no_pulse", 32'(dv_count - dv_base), 32'h0);
    start_frame(1'b0);
    send_bits(16'hBEEF, N, 1'b0, 1'b0);
    check("arst_beef", 32'(DATA), 32'hBEEF);
    check("arst_beef_full", 32'(FULL), 32'h1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_deser.md
SHIFT_DESER -- requirements
Module: shift_deser

Interface
REQ-001 Parameter N, default 16: parallel word width in bits; legal range N >= 2.
REQ-002 CLK  input  1  clock; all state changes on the rising edge except reset.
REQ-003 A_CLR_N  input  1  reset, asynchronous, active-low.
REQ-004 START  input  1  frame-start strobe; sampled each rising edge.
REQ-005 SIN  input  1  serial data bit, MSB of the word first.
REQ-006 SIN_VALID  input  1  SIN carries a valid bit this cycle.
REQ-007 RD  input  1  consumer acknowledges DATA; clears FULL.
REQ-008 DATA  output  N  last completed word, held until the next word completes.
REQ-009 DATA_VALID  output  1  one-cycle pulse in the cycle after a word completes.
REQ-010 FULL  output  1  DATA holds an unacknowledged word.
REQ-011 BUSY  output  1  high while in state SHIFT.
REQ-012 OVERRUN  output  1  sticky: a word completed while FULL was set and not being acknowledged.

Function
REQ-013 The block SHALL implement two states: IDLE and SHIFT. BUSY SHALL be 1 in SHIFT and 0 in IDLE.
REQ-014 IDLE: START=1 -> SHIFT, with bit counter 0 and shift register cleared. SIN_VALID SHALL be ignored in IDLE, including in the START cycle.
REQ-015 SHIFT, SIN_VALID=1, START=0: shift register <= {shreg[N-2:0], SIN}; counter increments by 1.
REQ-016 SHIFT, SIN_VALID=0, START=0: shift register and counter SHALL hold; there is no timeout.
REQ-017 On the Nth accepted bit (counter = N-1 with SIN_VALID=1):
- DATA <= {shreg[N-2:0], SIN}.
- DATA_VALID = 1 for exactly the next cycle.
- FULL <= 1.
- Counter <= 0.
- State -> IDLE.
REQ-018 Latency SHALL be 1 cycle: from the edge sampling the Nth bit to DATA/DATA_VALID updated.
REQ-019 SHIFT with START=1: the frame SHALL restart. Counter <= 0 and shift register cleared; the partial word is discarded with no DATA_VALID. A SIN_VALID in the same cycle is discarded (START wins).
REQ-020 START=1 on the completion cycle (counter = N-1, SIN_VALID=1): START wins per REQ-019 and no word completes.
REQ-021 RD=1 SHALL clear FULL on the next edge. RD has no effect when FULL=0.
REQ-022 Word completes while FULL=1 and RD=0:
- DATA is overwritten with the new word.
- DATA_VALID pulses.
- FULL stays 1.
- OVERRUN <= 1.
REQ-023 Word completes with RD=1 in the same cycle: FULL SHALL remain 1 and OVERRUN SHALL NOT be set.
REQ-024 OVERRUN SHALL clear only on reset or on an RD=1 cycle with no simultaneous overrun event. An overrun event takes priority over the clear.
REQ-025 The counter SHALL be $clog2(N) bits wide and SHALL never exceed N-1. No wrap-around occurs in SHIFT because completion returns the block to IDLE.
REQ-026 Bit order SHALL be the exact inverse of a left-shifting parallel-load transmitter: the first accepted bit lands in DATA[N-1] and the last in DATA[0].

Reset
REQ-027 A_CLR_N=0 SHALL immediately, without waiting for CLK:
- Force state IDLE.
- Set counter and shift register to 0.
- Set DATA to 0.
- Set DATA_VALID, FULL, BUSY and OVERRUN to 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial word with no DATA_VALID.
REQ-029 After A_CLR_N rises, the first START edge SHALL be honoured normally.

Verification
REQ-030 Basic (N=16): START, then 16 valid bits of 0xA5C3, MSB first -> DATA=0xA5C3, one DATA_VALID pulse, FULL=1, BUSY=0.
REQ-031 Gaps: same word with SIN_VALID=0 gaps of 1-5 cycles between bits -> identical DATA=0xA5C3 and a single pulse.
REQ-032 Restart: START, 7 bits, START again, then 16 bits of 0x1234 -> DATA=0x1234 and exactly one DATA_VALID.
REQ-033 Overrun: receive 0x00FF with no RD, then 0xFF00 -> DATA=0xFF00, OVERRUN=1, FULL=1. An RD then clears FULL and OVERRUN on the next edge.
REQ-034 RD on completion: RD=1 on the 16th-bit cycle with FULL=1 -> FULL=1, OVERRUN=0.
REQ-035 Async reset: assert A_CLR_N=0 between clock edges after 10 bits -> all outputs 0 before the next edge. A subsequent full frame of 0xBEEF -> DATA=0xBEEF.
